// File: rtl/gauss_pkg.sv
// Shared definitions for the gauss_stream convolution filter.
//   LAT                : input-to-output latency in clock cycles
//   acc_w()            : accumulator width for a given pixel/coef width and kernel size
//   round_bias()       : half-LSB rounding constant for a given normalisation shift
//   GAUSS_COEF_DEFAULT : 5x5 binomial kernel (outer product of 1,4,6,4,1; sum 256)
//   gauss_ctl_t        : per-pixel control bits carried down the pipeline
package gauss_pkg;

  localparam int unsigned LAT = 4;

  localparam int unsigned BinomK     = 5;
  localparam int unsigned BinomCoefW = 8;

  function automatic int unsigned acc_w(input int unsigned pix_w, input int unsigned coef_w,
                                        input int unsigned k);
    return pix_w + coef_w + $clog2(k * k);
  endfunction

  function automatic int unsigned round_bias(input int unsigned norm_shift);
    return (norm_shift == 0) ? 0 : (32'd1 << (norm_shift - 1));
  endfunction

  // Row i of Pascal's triangle for n=4.
  function automatic int unsigned binom4(input int unsigned i);
    case (i)
      0, 4:    return 1;
      1, 3:    return 4;
      default: return 6;
    endcase
  endfunction

  function automatic logic [BinomK*BinomK*BinomCoefW-1:0] binom5_coef();
    logic [BinomK*BinomK*BinomCoefW-1:0] v;
    v = '0;
    for (int unsigned r = 0; r < BinomK; r++) begin
      for (int unsigned c = 0; c < BinomK; c++) begin
        v[BinomCoefW*(r*BinomK+c) +: BinomCoefW] = BinomCoefW'(binom4(r) * binom4(c));
      end
    end
    return v;
  endfunction

  localparam logic [BinomK*BinomK*BinomCoefW-1:0] GAUSS_COEF_DEFAULT = binom5_coef();

  typedef struct packed {
    logic valid;
    logic sof;
    logic raw;  // pass the window centre instead of the filtered value
  } gauss_ctl_t;

endpackage

// File: rtl/gauss_line_buf.sv
// K-1 cascaded line RAMs for the gauss_stream window.
//   clk_i    : pixel clock
//   wr_en_i  : in_valid; writes every line and loads the tap registers
//   col_i    : column address of the incoming pixel
//   pix_i    : incoming pixel, written into the youngest line
//   tap_o[j] : pixel at col_i from j+1 lines ago, registered on wr_en_i
module gauss_line_buf #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned COL_W    = 10
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] tap_o [NUM_TAPS]
);

  // Old content of each line at col_i; each line feeds the next older one.
  logic [PIX_W-1:0] rd_data [NUM_TAPS];
  logic [PIX_W-1:0] wr_data [NUM_TAPS];

  for (genvar j = 0; j < NUM_TAPS; j++) begin : g_line
    logic [PIX_W-1:0] mem_q [IMG_W];
    logic [PIX_W-1:0] tap_q;

    if (j == 0) begin : g_first
      assign wr_data[j] = pix_i;
    end else begin : g_cascade
      assign wr_data[j] = rd_data[j-1];
    end

    assign rd_data[j] = mem_q[col_i];
    assign tap_o[j]   = tap_q;

    // Contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
        mem_q[col_i] <= wr_data[j];
        tap_q        <= rd_data[j];
      end
    end
  end

endmodule

// File: rtl/gauss_stream.sv
// Streaming KxK 2-D convolution filter with 4-cycle latency.
//   clk, reset_n         : pixel clock, asynchronous active-low reset
//   en_gauss, gauss_coef : enable and unsigned coefficients, shadowed on in_valid & in_sof
//   in_valid/sof/eol     : input pixel qualifiers
//   in_pixel             : input pixel
//   out_valid/out_sof    : input qualifiers delayed by LAT
//   out_pixel            : filtered pixel for the window centred at (row-H, col-H), or the
//                          raw centre at borders, outside a frame, or when disabled
// Stages: S1 window + raw flag, S2 products, S3 row sums, S4 sum/round/saturate/select.
module gauss_stream
  import gauss_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned K          = 5,
  parameter int unsigned COEF_W     = 8,
  parameter int unsigned NORM_SHIFT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_gauss,
  input  logic [K*K*COEF_W-1:0] gauss_coef,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  in_eol,
  input  logic [PIX_W-1:0]      in_pixel,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic [PIX_W-1:0]      out_pixel
);

  localparam int unsigned H      = K / 2;
  localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W  = 16;
  localparam int unsigned PROD_W = PIX_W + COEF_W;
  localparam int unsigned ACC_W  = acc_w(PIX_W, COEF_W, K);
  localparam int unsigned SUM_W  = ACC_W + 1;  // headroom for the rounding bias

  localparam logic [SUM_W-1:0] RoundBias = SUM_W'(round_bias(NORM_SHIFT));
  localparam logic [SUM_W-1:0] PixMax    = SUM_W'({PIX_W{1'b1}});
  localparam logic [COL_W-1:0] ColMax    = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] RowMax    = '1;
  localparam logic [COL_W-1:0] ColBorder = COL_W'(2 * H);
  localparam logic [ROW_W-1:0] RowBorder = ROW_W'(2 * H);

  // ---------------------------------------------------------------------------------------------
  // Position counters and frame shadows
  // ---------------------------------------------------------------------------------------------
  logic [COL_W-1:0]      col_q, col_d, pix_col;
  logic [ROW_W-1:0]      row_q, row_d, pix_row;
  logic                  frame_active_q, frame_active_d;
  logic                  en_q, en_d;
  logic [K*K*COEF_W-1:0] coef_q, coef_d;
  logic                  en_eff, active_eff, raw_now;

  always_comb begin
    // An sof pixel is always at (0,0), whatever the counters say.
    pix_col        = in_sof ? '0 : col_q;
    pix_row        = in_sof ? '0 : row_q;
    col_d          = col_q;
    row_d          = row_q;
    frame_active_d = frame_active_q;
    en_d           = en_q;
    coef_d         = coef_q;
    if (in_valid) begin
      if (in_sof) begin
        frame_active_d = 1'b1;
        en_d           = en_gauss;
        coef_d         = gauss_coef;
      end
      if (in_eol) begin
        col_d = '0;
        if (in_sof) begin
          row_d = '0;
        end else if (row_q != RowMax) begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = (pix_col == ColMax) ? pix_col : pix_col + 1'b1;
        row_d = pix_row;
      end
    end
  end

  // The sof pixel must already see the newly shadowed enable.
  assign en_eff     = in_sof ? en_gauss : en_q;
  assign active_eff = in_sof | frame_active_q;
  assign raw_now    = ~active_eff | ~en_eff | (pix_row < RowBorder) | (pix_col < ColBorder);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q          <= '0;
      row_q          <= '0;
      frame_active_q <= 1'b0;
      en_q           <= 1'b0;
      coef_q         <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      frame_active_q <= frame_active_d;
      en_q           <= en_d;
      coef_q         <= coef_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S1: window. Columns 0..K-2 live here; column K-1 is the line-buffer taps plus pix_q,
  // all loaded on the same in_valid edge.
  // ---------------------------------------------------------------------------------------------
  logic [PIX_W-1:0] tap    [K-1];
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] wcol_q [K-1][K];  // [column][row], column 0 oldest
  logic [PIX_W-1:0] win    [K][K];    // [row][column], row 0 oldest line
  gauss_ctl_t       s1_ctl_q;

  gauss_line_buf #(
    .PIX_W   (PIX_W),
    .IMG_W   (IMG_W),
    .NUM_TAPS(K - 1),
    .COL_W   (COL_W)
  ) u_line_buf (
    .clk_i  (clk),
    .wr_en_i(in_valid),
    .col_i  (pix_col),
    .pix_i  (in_pixel),
    .tap_o  (tap)
  );

  for (genvar r = 0; r < K; r++) begin : g_win_r
    for (genvar c = 0; c < K - 1; c++) begin : g_win_c
      assign win[r][c] = wcol_q[c][r];
    end
    if (r == K - 1) begin : g_new_pix
      assign win[r][K-1] = pix_q;
    end else begin : g_new_tap
      assign win[r][K-1] = tap[K-2-r];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q    <= '0;
      s1_ctl_q <= '0;
      for (int c = 0; c < K - 1; c++) begin
        for (int r = 0; r < K; r++) begin
          wcol_q[c][r] <= '0;
        end
      end
    end else begin
      s1_ctl_q.valid <= in_valid;
      s1_ctl_q.sof   <= in_valid & in_sof;
      s1_ctl_q.raw   <= raw_now;
      if (in_valid) begin
        pix_q <= in_pixel;
        for (int c = 0; c < K - 2; c++) begin
          wcol_q[c] <= wcol_q[c+1];
        end
        for (int r = 0; r < K; r++) begin
          wcol_q[K-2][r] <= win[r][K-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S2: products, S3: per-row sums
  // ---------------------------------------------------------------------------------------------
  logic [PROD_W-1:0] prod_q    [K][K];
  logic [ACC_W-1:0]  row_sum_d [K];
  logic [ACC_W-1:0]  row_sum_q [K];
  logic [PIX_W-1:0]  s2_ctr_q, s3_ctr_q;
  gauss_ctl_t        s2_ctl_q, s3_ctl_q;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      row_sum_d[r] = '0;
      for (int c = 0; c < K; c++) begin
        row_sum_d[r] = row_sum_d[r] + ACC_W'(prod_q[r][c]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_ctl_q <= '0;
      s3_ctl_q <= '0;
      s2_ctr_q <= '0;
      s3_ctr_q <= '0;
      for (int r = 0; r < K; r++) begin
        row_sum_q[r] <= '0;
        for (int c = 0; c < K; c++) begin
          prod_q[r][c] <= '0;
        end
      end
    end else begin
      s2_ctl_q <= s1_ctl_q;
      s2_ctr_q <= win[H][H];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          prod_q[r][c] <= PROD_W'(win[r][c]) * PROD_W'(coef_q[COEF_W*(r*K+c) +: COEF_W]);
        end
      end
      s3_ctl_q  <= s2_ctl_q;
      s3_ctr_q  <= s2_ctr_q;
      row_sum_q <= row_sum_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // S4: final sum, round half up, saturate, select
  // ---------------------------------------------------------------------------------------------
  logic [SUM_W-1:0] total, total_rnd, total_shr;
  logic [PIX_W-1:0] filt_pix;
  logic             out_valid_q, out_sof_q;
  logic [PIX_W-1:0] out_pixel_q;

  always_comb begin
    total = '0;
    for (int r = 0; r < K; r++) begin
      total = total + SUM_W'(row_sum_q[r]);
    end
    total_rnd = total + RoundBias;
    total_shr = total_rnd >> NORM_SHIFT;
    filt_pix  = (total_shr > PixMax) ? '1 : total_shr[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      out_valid_q <= s3_ctl_q.valid;
      out_sof_q   <= s3_ctl_q.sof;
      out_pixel_q <= s3_ctl_q.raw ? s3_ctr_q : filt_pix;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_gauss_stream.sv
// Directed bench for gauss_stream with default parameters (K=5, 8-bit pixels/coefs, shift 8).
module tb_gauss_stream;
  import gauss_pkg::*;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned IMG_W      = 640;
  localparam int unsigned K          = 5;
  localparam int unsigned COEF_W     = 8;
  localparam int unsigned NORM_SHIFT = 8;
  localparam int unsigned CW         = K * K * COEF_W;
  localparam int          W          = 16;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b1;
  logic             en_gauss   = 1'b0;
  logic [CW-1:0]    gauss_coef = '0;
  logic             in_valid   = 1'b0;
  logic             in_sof     = 1'b0;
  logic             in_eol     = 1'b0;
  logic [PIX_W-1:0] in_pixel   = '0;
  logic             out_valid;
  logic             out_sof;
  logic [PIX_W-1:0] out_pixel;

  int checks = 0;
  int errors = 0;

  logic [PIX_W-1:0] cap_pix [$];
  logic             cap_sof [$];

  gauss_stream #(
    .PIX_W     (PIX_W),
    .IMG_W     (IMG_W),
    .K         (K),
    .COEF_W    (COEF_W),
    .NORM_SHIFT(NORM_SHIFT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_gauss  (en_gauss),
    .gauss_coef(gauss_coef),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_eol    (in_eol),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_pixel (out_pixel)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_pix.push_back(out_pixel);
      cap_sof.push_back(out_sof);
    end
  end

  // Modes: 0 flat 100, 1 impulse at (8,8), 2 all 255, 4 nonlinear pattern.
  function automatic logic [PIX_W-1:0] pix_val(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'd100;
      1:       return (r == 8 && c == 8) ? 8'd255 : 8'd0;
      2:       return 8'd255;
      default: return 8'((r * 29) + (c * c * 7));
    endcase
  endfunction

  function automatic int binom(input int i);
    case (i)
      0, 4:    return 1;
      1, 3:    return 4;
      default: return 6;
    endcase
  endfunction

  task automatic clear_cap();
    cap_pix.delete();
    cap_sof.delete();
  endtask

  // Leaves the last pixel driven so frames can follow back-to-back.
  task automatic send_frame(input int w, input int h, input int mode, input bit with_sof,
                            input int coef_zero_at);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        @(negedge clk);
        if (r * w + c == coef_zero_at) gauss_coef = '0;
        in_valid = 1'b1;
        in_sof   = with_sof && r == 0 && c == 0;
        in_eol   = (c == w - 1);
        in_pixel = pix_val(mode, r, c);
      end
    end
  endtask

  task automatic flush();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_sof !== 1'b0) begin
      errors++; $display("FAIL reset_out_sof got %b want 0", out_sof);
    end
    checks++;
    if (out_pixel !== 8'd0) begin
      errors++; $display("FAIL reset_out_pixel got %0d want 0", out_pixel);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_flat();
    int r, c;
    en_gauss   = 1'b1;
    gauss_coef = GAUSS_COEF_DEFAULT;
    clear_cap();
    send_frame(W, 8, 0, 1'b1, -1);
    flush();
    checks++;
    if (cap_pix.size() != 128) begin
      errors++; $display("FAIL flat_count got %0d want 128", cap_pix.size());
    end
    for (int k = 0; k < cap_pix.size() && k < 128; k++) begin
      r = k / W; c = k % W;
      checks++;
      if (cap_sof[k] !== (k == 0)) begin
        errors++; $display("FAIL flat_sof k=%0d got %b want %b", k, cap_sof[k], k == 0);
      end
      if (r >= 2 && c >= 2) begin
        checks++;
        if (cap_pix[k] !== 8'd100) begin
          errors++; $display("FAIL flat_pix r=%0d c=%0d got %0d want 100", r, c, cap_pix[k]);
        end
      end
    end
  endtask

  task automatic test_impulse();
    int r, c, exp_v;
    en_gauss   = 1'b1;
    gauss_coef = GAUSS_COEF_DEFAULT;
    clear_cap();
    send_frame(W, 14, 1, 1'b1, -1);
    flush();
    checks++;
    if (cap_pix.size() != W * 14) begin
      errors++; $display("FAIL impulse_count got %0d want %0d", cap_pix.size(), W * 14);
    end
    for (int k = 0; k < cap_pix.size() && k < W * 14; k++) begin
      r = k / W; c = k % W;
      if (r >= 2 && c >= 2) begin
        exp_v = 0;
        if (r >= 8 && r <= 12 && c >= 8 && c <= 12)
          exp_v = (255 * binom(r - 8) * binom(c - 8) + 128) >> 8;
        checks++;
        if (cap_pix[k] !== 8'(exp_v)) begin
          errors++;
          $display("FAIL impulse_pix r=%0d c=%0d got %0d want %0d", r, c, cap_pix[k], exp_v);
        end
      end
    end
    checks++;
    if (cap_pix.size() > 10 * W + 10 && cap_pix[10 * W + 10] !== 8'd36) begin
      errors++; $display("FAIL impulse_centre got %0d want 36", cap_pix[10 * W + 10]);
    end
  endtask

  task automatic test_saturation();
    int r, c;
    en_gauss   = 1'b1;
    gauss_coef = '1;
    clear_cap();
    send_frame(W, 8, 2, 1'b1, -1);
    flush();
    checks++;
    if (cap_pix.size() != 128) begin
      errors++; $display("FAIL sat_count got %0d want 128", cap_pix.size());
    end
    for (int k = 0; k < cap_pix.size() && k < 128; k++) begin
      r = k / W; c = k % W;
      if (r >= 2 && c >= 2) begin
        checks++;
        if (cap_pix[k] !== 8'd255) begin
          errors++; $display("FAIL sat_pix r=%0d c=%0d got %0d want 255", r, c, cap_pix[k]);
        end
      end
    end
    gauss_coef = GAUSS_COEF_DEFAULT;
  endtask

  task automatic test_bypass();
    int r, c, n;
    logic [PIX_W-1:0] exp_v;
    en_gauss   = 1'b0;
    gauss_coef = GAUSS_COEF_DEFAULT;
    clear_cap();
    send_frame(W, 8, 4, 1'b1, -1);
    flush();
    checks++;
    if (cap_pix.size() != 128) begin
      errors++; $display("FAIL bypass_count got %0d want 128", cap_pix.size());
    end
    for (int k = 0; k < cap_pix.size() && k < 128; k++) begin
      r = k / W; c = k % W;
      if (r >= 2 && c >= 2) begin
        exp_v = pix_val(4, r - 2, c - 2);
        checks++;
        if (cap_pix[k] !== exp_v) begin
          errors++;
          $display("FAIL bypass_pix r=%0d c=%0d got %0d want %0d", r, c, cap_pix[k], exp_v);
        end
      end
    end
    // Latency of a single isolated pixel.
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b1; in_eol = 1'b0; in_pixel = 8'd7;
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != LAT) begin
      errors++; $display("FAIL bypass_latency got %0d want %0d", n, LAT);
    end
    checks++;
    if (out_sof !== 1'b1) begin
      errors++; $display("FAIL bypass_latency_sof got %b want 1", out_sof);
    end
    flush();
    clear_cap();
  endtask

  task automatic test_coef_shadow();
    int r, c, kk;
    logic [PIX_W-1:0] exp_v;
    en_gauss   = 1'b1;
    gauss_coef = GAUSS_COEF_DEFAULT;
    clear_cap();
    send_frame(W, 8, 0, 1'b1, 5 * W);
    send_frame(W, 8, 0, 1'b1, -1);
    flush();
    checks++;
    if (cap_pix.size() != 256) begin
      errors++; $display("FAIL shadow_count got %0d want 256", cap_pix.size());
    end
    checks++;
    if (cap_pix.size() > 128 && cap_sof[128] !== 1'b1) begin
      errors++; $display("FAIL shadow_sof2 got %b want 1", cap_sof[128]);
    end
    for (int k = 0; k < cap_pix.size() && k < 256; k++) begin
      kk = k % 128; r = kk / W; c = kk % W;
      if (r >= 2 && c >= 2) begin
        exp_v = (k >= 128 && r >= 4 && c >= 4) ? 8'd0 : 8'd100;
        checks++;
        if (cap_pix[k] !== exp_v) begin
          errors++;
          $display("FAIL shadow_pix frame=%0d r=%0d c=%0d got %0d want %0d", k / 128, r, c,
                   cap_pix[k], exp_v);
        end
      end
    end
    gauss_coef = GAUSS_COEF_DEFAULT;
  endtask

  task automatic test_reset_mid_frame();
    int r, c;
    logic [PIX_W-1:0] exp_v;
    en_gauss   = 1'b1;
    gauss_coef = GAUSS_COEF_DEFAULT;
    send_frame(W, 3, 0, 1'b1, -1);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    reset_n  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_pixel !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b s=%b p=%0d want 0 0 0", out_valid, out_sof,
               out_pixel);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_cap();
    // No sof: frame inactive, so everything is raw.
    send_frame(W, 3, 4, 1'b0, -1);
    flush();
    checks++;
    if (cap_pix.size() != 48) begin
      errors++; $display("FAIL midreset_count got %0d want 48", cap_pix.size());
    end
    for (int k = 0; k < cap_pix.size() && k < 48; k++) begin
      r = k / W; c = k % W;
      checks++;
      if (cap_sof[k] !== 1'b0) begin
        errors++; $display("FAIL midreset_sof k=%0d got %b want 0", k, cap_sof[k]);
      end
      if (r >= 2 && c >= 2) begin
        exp_v = pix_val(4, r - 2, c - 2);
        checks++;
        if (cap_pix[k] !== exp_v) begin
          errors++;
          $display("FAIL midreset_raw r=%0d c=%0d got %0d want %0d", r, c, cap_pix[k], exp_v);
        end
      end
    end
    clear_cap();
    send_frame(W, 14, 1, 1'b1, -1);
    flush();
    checks++;
    if (cap_pix.size() > 0 && cap_sof[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_next_sof got %b want 1", cap_sof[0]);
    end
    checks++;
    if (cap_pix.size() != W * 14 || cap_pix[10 * W + 10] !== 8'd36) begin
      errors++;
      $display("FAIL midreset_next_centre count=%0d want %0d, centre want 36", cap_pix.size(),
               W * 14);
    end
    checks++;
    if (cap_pix.size() == W * 14 && cap_pix[9 * W + 10] !== 8'd24) begin
      errors++; $display("FAIL midreset_next_pix got %0d want 24", cap_pix[9 * W + 10]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_flat();
    test_impulse();
    test_saturation();
    test_bypass();
    test_coef_shadow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
